instr_assembler: RTL and testbench

INSTR_ASSEMBLER -- requirements
Module: instr_assembler

---
 rtl/instr_assembler.sv | 113 +++++++++++
 tb/tb_instr_assembler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_assembler.sv
// Bytecode instruction assembler: collects an opcode and its operand bytes from a
// byte stream and holds the finished instruction until the downstream stage takes it.
module instr_assembler #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               byte_in,
  input  logic                     byte_ready,
  output logic                     byte_start,
  input  logic                     flush,
  input  logic [ADDRESS_WIDTH-1:0] flush_pc,
  output logic                     instr_valid,
  input  logic                     instr_accept,
  output logic [7:0]               opcode,
  output logic [31:0]              operands,
  output logic [2:0]               operand_count,
  output logic [ADDRESS_WIDTH-1:0] instr_pc
);

  typedef enum logic [1:0] {
    FETCH_OP   = 2'd0,
    FETCH_OPND = 2'd1,
    HOLD       = 2'd2
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] pc_count;
  logic [2:0]               remaining;
  logic [2:0]               decoded_len;
  logic                     consume;

  function automatic logic [2:0] operand_length(input logic [7:0] op);
    case (op) inside
      8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC:
        operand_length = 3'd1;
      8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8], 8'hBB, 8'hBD,
      8'hC0, 8'hC1, 8'hC6, 8'hC7:
        operand_length = 3'd2;
      8'hC5:
        operand_length = 3'd3;
      8'hB9, 8'hBA, 8'hC8, 8'hC9:
        operand_length = 3'd4;
      default:
        operand_length = 3'd0;
    endcase
  endfunction

  // Reset is folded in so byte requests drop the moment reset asserts.
  assign byte_start  = !reset && !flush && ((state == FETCH_OP) || (state == FETCH_OPND));
  assign consume     = byte_start && byte_ready;
  assign decoded_len = operand_length(byte_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FETCH_OP;
      pc_count      <= '0;
      remaining     <= 3'd0;
      opcode        <= 8'h00;
      operands      <= 32'h0;
      operand_count <= 3'd0;
      instr_pc      <= '0;
      instr_valid   <= 1'b0;
    end else if (flush) begin
      // A redirect drops any partial or held instruction; the presented fields are left as-is.
      state       <= FETCH_OP;
      pc_count    <= flush_pc;
      remaining   <= 3'd0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH_OP: begin
          if (consume) begin
            opcode        <= byte_in;
            instr_pc      <= pc_count;
            operands      <= 32'h0;
            operand_count <= decoded_len;
            remaining     <= decoded_len;
            pc_count      <= pc_count + 1'b1;
            if (decoded_len == 3'd0) begin
              state       <= HOLD;
              instr_valid <= 1'b1;
            end else begin
              state <= FETCH_OPND;
            end
          end
        end
        FETCH_OPND: begin
          if (consume) begin
            operands  <= {operands[23:0], byte_in};
            remaining <= remaining - 3'd1;
            pc_count  <= pc_count + 1'b1;
            if (remaining == 3'd1) begin
              state       <= HOLD;
              instr_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (instr_accept) begin
            state       <= FETCH_OP;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= FETCH_OP;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_assembler.sv
// Self-checking bench for instr_assembler: directed scenarios plus a randomized
// instruction stream compared against an instruction-level reference model.
module tb_instr_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_ready;
  logic        byte_start;
  logic        flush;
  logic [7:0]  flush_pc;
  logic        instr_valid;
  logic        instr_accept;
  logic [7:0]  opcode;
  logic [31:0] operands;
  logic [2:0]  operand_count;
  logic [7:0]  instr_pc;

  typedef struct {
    int op;
    int opnds;
    int cnt;
    int pc;
  } instr_t;

  int checks   = 0;
  int failures = 0;
  int model_pc = 0;

  instr_assembler #(.ADDRESS_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_ready(byte_ready),
    .byte_start(byte_start), .flush(flush), .flush_pc(flush_pc),
    .instr_valid(instr_valid), .instr_accept(instr_accept), .opcode(opcode),
    .operands(operands), .operand_count(operand_count), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Operand byte count for an opcode, straight from the opcode table.
  function automatic int ref_len(input int op);
    if (op inside {8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC}) return 1;
    if (op inside {8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8], 8'hBB,
                   8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7}) return 2;
    if (op == 8'hC5) return 3;
    if (op inside {8'hB9, 8'hBA, 8'hC8, 8'hC9}) return 4;
    return 0;
  endfunction

  task automatic check_instr(input string tag, input int op, input int opnds, input int cnt, input int pc);
    checkOutput({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    checkOutput({tag, "_opcode"}, {24'b0, opcode}, op);
    checkOutput({tag, "_operands"}, operands, opnds);
    checkOutput({tag, "_count"}, {29'b0, operand_count}, cnt);
    checkOutput({tag, "_pc"}, {24'b0, instr_pc}, pc);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    checkOutput({tag, "_byte_start"}, {31'b0, byte_start}, 32'd0);
    checkOutput({tag, "_opcode"}, {24'b0, opcode}, 32'd0);
    checkOutput({tag, "_operands"}, operands, 32'd0);
    checkOutput({tag, "_count"}, {29'b0, operand_count}, 32'd0);
    checkOutput({tag, "_pc"}, {24'b0, instr_pc}, 32'd0);
  endtask

  // Presents one byte for exactly one clock edge; the assembler must be requesting it.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    checkOutput("byte_start_req", {31'b0, byte_start}, 32'd1);
    byte_ready = 1'b1;
    byte_in    = b;
    @(posedge clk);
    @(negedge clk);
    byte_ready = 1'b0;
    byte_in    = 8'hEE;
    model_pc   = (model_pc + 1) % 256;
  endtask

  task automatic accept_instr(input string tag);
    instr_accept = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_accept = 1'b0;
    checkOutput({tag, "_valid_drop"}, {31'b0, instr_valid}, 32'd0);
    checkOutput({tag, "_restart"}, {31'b0, byte_start}, 32'd1);
  endtask

  task automatic do_reset(input string tag);
    #3 reset = 1'b1;
    #1 check_all_zero(tag);
    #4 reset = 1'b0;
    model_pc = 0;
  endtask

  task automatic run_random(input int n_instr);
    logic [7:0] bytes[$];
    instr_t     exp_q[$];
    instr_t     e;
    int         cycles;
    logic [7:0] b;
    for (int i = 0; i < n_instr; i++) begin
      e.op    = int'($urandom_range(0, 255));
      e.cnt   = ref_len(e.op);
      e.pc    = model_pc;
      e.opnds = 0;
      bytes.push_back(e.op[7:0]);
      for (int k = 0; k < e.cnt; k++) begin
        b = 8'($urandom);
        e.opnds = (e.opnds << 8) | int'(b);
        bytes.push_back(b);
      end
      model_pc = (model_pc + 1 + e.cnt) % 256;
      exp_q.push_back(e);
    end
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (instr_valid) begin
        checkOutput("rnd_hold_byte_start", {31'b0, byte_start}, 32'd0);
        if (exp_q.size() > 0)
          check_instr("rnd", exp_q[0].op, exp_q[0].opnds, exp_q[0].cnt, exp_q[0].pc);
      end
      instr_accept = 1'($urandom_range(0, 1));
      if (bytes.size() > 0 && $urandom_range(0, 3) != 0) begin
        byte_ready = 1'b1;
        byte_in    = bytes[0];
      end else begin
        byte_ready = 1'b0;
        byte_in    = 8'($urandom);
      end
      if (byte_ready && byte_start) void'(bytes.pop_front());
      if (instr_valid && instr_accept) void'(exp_q.pop_front());
    end
    checkOutput("rnd_remaining_instrs", exp_q.size(), 32'd0);
    byte_ready   = 1'b0;
    instr_accept = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    byte_in      = 8'h00;
    byte_ready   = 1'b0;
    flush        = 1'b0;
    flush_pc     = 8'h00;
    instr_accept = 1'b0;
    #12 reset = 1'b0;

    // Single zero-operand opcode straight after reset
    do_reset("rst1");
    applyStimulus(8'h04);
    check_instr("op04", 32'h04, 32'h0, 0, 0);
    accept_instr("op04");

    // Two-operand instruction then the next opcode's address
    applyStimulus(8'h11);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    check_instr("op11", 32'h11, 32'h1234, 2, 1);
    accept_instr("op11");
    applyStimulus(8'h00);
    check_instr("next_pc", 32'h00, 32'h0, 0, 4);
    accept_instr("next_pc");

    // Four operands with gaps between them
    do_reset("rst2");
    applyStimulus(8'hC8);
    for (int i = 1; i <= 4; i++) begin
      repeat (2) @(negedge clk);
      checkOutput("gap_no_valid", {31'b0, instr_valid}, 32'd0);
      applyStimulus(8'(i));
    end
    check_instr("opC8", 32'hC8, 32'h01020304, 4, 0);
    accept_instr("opC8");

    // Held instruction stays stable while not accepted
    applyStimulus(8'h10);
    applyStimulus(8'h7F);
    for (int i = 0; i < 3; i++) begin
      check_instr("hold", 32'h10, 32'h7F, 1, 5);
      checkOutput("hold_byte_start", {31'b0, byte_start}, 32'd0);
      @(negedge clk);
    end
    accept_instr("hold");

    // Flush after the opcode and one operand
    applyStimulus(8'h11);
    applyStimulus(8'hAA);
    flush      = 1'b1;
    flush_pc   = 8'h40;
    byte_ready = 1'b1;
    byte_in    = 8'h55;
    #1 checkOutput("flush_byte_start", {31'b0, byte_start}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush      = 1'b0;
    byte_ready = 1'b0;
    checkOutput("flush_valid", {31'b0, instr_valid}, 32'd0);
    model_pc = 8'h40;
    applyStimulus(8'h00);
    check_instr("after_flush", 32'h00, 32'h0, 0, 32'h40);
    accept_instr("after_flush");

    // Asynchronous reset in the middle of an operand fetch
    applyStimulus(8'hC9);
    applyStimulus(8'h01);
    @(posedge clk);
    do_reset("rst_mid");
    applyStimulus(8'h04);
    check_instr("post_reset", 32'h04, 32'h0, 0, 0);
    accept_instr("post_reset");

    run_random(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
